// File: rtl/cfu_pkg.sv
// Shared definitions for the condition/flag unit: flag bit positions,
// condition-code encodings and the condition evaluator.
package cfu_pkg;

    // Bit positions inside the {N,V,Z,C} flag vector
    localparam int FLG_N = 3;
    localparam int FLG_V = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_C = 0;

    typedef logic [3:0] flags_t;

    // Condition-code encodings seen on cond_code
    localparam logic [3:0] CC_NE  = 4'd0;
    localparam logic [3:0] CC_EQ  = 4'd1;
    localparam logic [3:0] CC_GT  = 4'd2;
    localparam logic [3:0] CC_LT  = 4'd3;
    localparam logic [3:0] CC_GE  = 4'd4;
    localparam logic [3:0] CC_LE  = 4'd5;
    localparam logic [3:0] CC_OV  = 4'd6;
    localparam logic [3:0] CC_UN  = 4'd7;
    localparam logic [3:0] CC_CS  = 4'd8;
    localparam logic [3:0] CC_CC  = 4'd9;
    localparam logic [3:0] CC_SGE = 4'd10;
    localparam logic [3:0] CC_SLT = 4'd11;
    localparam logic [3:0] CC_UGT = 4'd12;
    localparam logic [3:0] CC_ULE = 4'd13;

    // Evaluate one condition code against a flag vector; reserved codes are false
    function automatic logic cond_eval(input logic [3:0] code, input flags_t f);
        logic n, v, z, c;
        logic res;
        n   = f[FLG_N];
        v   = f[FLG_V];
        z   = f[FLG_Z];
        c   = f[FLG_C];
        res = 1'b0;
        case (code)
            CC_NE:   res = ~z;
            CC_EQ:   res = z;
            CC_GT:   res = ~z & ~n;
            CC_LT:   res = n;
            CC_GE:   res = ~n | z;
            CC_LE:   res = n | z;
            CC_OV:   res = v;
            CC_UN:   res = 1'b1;
            CC_CS:   res = c;
            CC_CC:   res = ~c;
            CC_SGE:  res = (n == v);
            CC_SLT:  res = (n != v);
            CC_UGT:  res = c & ~z;
            CC_ULE:  res = ~c | z;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/flag_stack.sv
// Small LIFO holding saved flag vectors across interrupt entry/return.
// Only the pointer is reset; entry contents are don't-care when empty.
import cfu_pkg::*;

module flag_stack #(
    parameter int DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   push,
    input  logic   pop,
    input  flags_t push_data,
    output flags_t top_data,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    flags_t             mem [DEPTH];
    logic [PTR_W-1:0]   ptr;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   top_idx;

    assign full    = (ptr == PTR_W'(DEPTH));
    assign empty   = (ptr == '0);
    assign wr_idx  = IDX_W'(ptr);
    assign top_idx = IDX_W'(ptr - 1'b1);
    assign top_data = mem[top_idx];

    // Stack pointer: push and pop are pre-qualified by the caller against full/empty
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (push) begin
            ptr <= ptr + 1'b1;
        end else if (pop) begin
            ptr <= ptr - 1'b1;
        end
    end

    // Entry storage
    // NOTE: storage arrays sit in their own reset-less block so they map onto plain
    // registers/RAM; the pointer alone defines which entries are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/cond_flag_unit.sv
// NVZC flag register with per-flag masked update, zero-latency bypass into the
// condition evaluator, in-flight writer tracking for branch stalls, and a flag
// save/restore stack for interrupts.
import cfu_pkg::*;

module cond_flag_unit #(
    parameter int DATA_W      = 16,
    parameter int MAX_PEND    = 3,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic              ex_wr_valid,
    input  logic [3:0]        ex_wr_mask,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_ovfl,
    input  logic              alu_carry,
    input  logic              flush,
    input  logic              cond_valid,
    input  logic [3:0]        cond_code,
    output logic              cond_true,
    output logic              cond_stall,
    input  logic              save,
    input  logic              restore,
    output logic [3:0]        flags,
    output logic              stk_err
);

    localparam int PEND_W = $clog2(MAX_PEND + 1);

    flags_t             flag_q;
    flags_t             ex_flags;
    flags_t             eff_flags;
    flags_t             stk_top;
    logic [PEND_W-1:0]  pending;
    logic [PEND_W-1:0]  pending_after_ex;
    logic               iss_fire;
    logic               stk_full;
    logic               stk_empty;
    logic               stk_push;
    logic               stk_pop;
    logic               stk_fault;

    // Candidate flag values produced by this cycle's execute result
    assign ex_flags = {alu_out[DATA_W-1], alu_ovfl, ~|alu_out, alu_carry};

    // Bypass: register merged per mask bit with the in-progress execute write
    // NOTE: every signal assigned in always_comb gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        eff_flags = flag_q;
        for (int i = 0; i < 4; i++) begin
            if (ex_wr_valid && ex_wr_mask[i]) begin
                eff_flags[i] = ex_flags[i];
            end
        end
    end

    // Pending writers and stall qualification
    assign iss_ready        = (pending != PEND_W'(MAX_PEND));
    assign iss_fire         = iss_valid & iss_ready;
    assign pending_after_ex = (ex_wr_valid && pending != '0) ? pending - 1'b1 : pending;
    assign cond_stall       = cond_valid & (pending_after_ex != '0);
    assign cond_true        = cond_valid & cond_eval(cond_code, eff_flags);
    assign flags            = flag_q;

    // Stack control: save and restore together is an error and does nothing
    assign stk_push  = save & ~restore & ~stk_full;
    assign stk_pop   = restore & ~save & ~stk_empty;
    assign stk_fault = (save & restore) | (save & stk_full) | (restore & stk_empty);

    // Pending-writer counter; flush wins over issue and execute
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else if (flush) begin
            pending <= '0;
        end else if (iss_fire && !ex_wr_valid) begin
            pending <= pending + 1'b1;
        end else if (!iss_fire && ex_wr_valid && pending != '0) begin
            pending <= pending - 1'b1;
        end
    end

    // Flag register: restore blocks the execute write; an ineffective restore holds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= '0;
        end else if (restore) begin
            if (stk_pop) begin
                flag_q <= stk_top;
            end
        end else begin
            flag_q <= eff_flags;
        end
    end

    // Sticky stack error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stk_err <= 1'b0;
        end else if (stk_fault) begin
            stk_err <= 1'b1;
        end
    end

    flag_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_flag_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (flag_q),
        .top_data  (stk_top),
        .full      (stk_full),
        .empty     (stk_empty)
    );

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench for cond_flag_unit: a behavioural model tracked per cycle
// plus directed sequences with hand-computed expectations.
module tb_cond_flag_unit;

    localparam int DATA_W      = 16;
    localparam int MAX_PEND    = 3;
    localparam int STACK_DEPTH = 4;

    logic              clk;
    logic              rst;
    logic              iss_valid;
    logic              iss_ready;
    logic              ex_wr_valid;
    logic [3:0]        ex_wr_mask;
    logic [DATA_W-1:0] alu_out;
    logic              alu_ovfl;
    logic              alu_carry;
    logic              flush;
    logic              cond_valid;
    logic [3:0]        cond_code;
    logic              cond_true;
    logic              cond_stall;
    logic              save;
    logic              restore;
    logic [3:0]        flags;
    logic              stk_err;

    int n_checks = 0;
    int n_fail   = 0;

    cond_flag_unit #(
        .DATA_W      (DATA_W),
        .MAX_PEND    (MAX_PEND),
        .STACK_DEPTH (STACK_DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .iss_valid   (iss_valid),
        .iss_ready   (iss_ready),
        .ex_wr_valid (ex_wr_valid),
        .ex_wr_mask  (ex_wr_mask),
        .alu_out     (alu_out),
        .alu_ovfl    (alu_ovfl),
        .alu_carry   (alu_carry),
        .flush       (flush),
        .cond_valid  (cond_valid),
        .cond_code   (cond_code),
        .cond_true   (cond_true),
        .cond_stall  (cond_stall),
        .save        (save),
        .restore     (restore),
        .flags       (flags),
        .stk_err     (stk_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Flags held as individual booleans, pending as a plain integer, stack as an array.
    bit m_n = 0, m_v = 0, m_z = 0, m_c = 0;
    int m_pend = 0;
    int m_sp   = 0;
    bit [3:0] m_stk [STACK_DEPTH];
    bit m_err  = 0;

    function automatic bit m_cond(input int code, input bit n, input bit v, input bit z, input bit c);
        case (code)
            0:  return !z;
            1:  return z;
            2:  return !z && !n;
            3:  return n;
            4:  return !n || z;
            5:  return n || z;
            6:  return v;
            7:  return 1'b1;
            8:  return c;
            9:  return !c;
            10: return n == v;
            11: return n != v;
            12: return c && !z;
            13: return !c || z;
            default: return 1'b0;
        endcase
    endfunction

    // Value a flag takes this cycle when the execute stage writes it
    function automatic bit m_pick(input bit cur, input int idx, input bit newv);
        return (ex_wr_valid && ex_wr_mask[idx]) ? newv : cur;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_n <= 0; m_v <= 0; m_z <= 0; m_c <= 0;
            m_pend <= 0;
            m_sp   <= 0;
            m_err  <= 0;
        end else begin
            if (restore) begin
                if (!save && m_sp > 0) begin
                    {m_n, m_v, m_z, m_c} <= m_stk[m_sp-1];
                end
            end else begin
                m_n <= m_pick(m_n, 3, alu_out[DATA_W-1]);
                m_v <= m_pick(m_v, 2, alu_ovfl);
                m_z <= m_pick(m_z, 1, alu_out == 0);
                m_c <= m_pick(m_c, 0, alu_carry);
            end
            if (flush) begin
                m_pend <= 0;
            end else begin
                int t;
                t = m_pend + ((iss_valid && m_pend < MAX_PEND) ? 1 : 0) - (ex_wr_valid ? 1 : 0);
                m_pend <= (t < 0) ? 0 : t;
            end
            if (save && restore) begin
                m_err <= 1;
            end else if (save) begin
                if (m_sp == STACK_DEPTH) m_err <= 1;
                else begin
                    m_stk[m_sp] <= {m_n, m_v, m_z, m_c};
                    m_sp <= m_sp + 1;
                end
            end else if (restore) begin
                if (m_sp == 0) m_err <= 1;
                else m_sp <= m_sp - 1;
            end
        end
    end

    // Compare process: outputs are combinational on state + current inputs
    always @(negedge clk) begin
        int  after_ex;
        bit  en, ev, ez, ec;
        bit  exp_stall;
        en = m_pick(m_n, 3, alu_out[DATA_W-1]);
        ev = m_pick(m_v, 2, alu_ovfl);
        ez = m_pick(m_z, 1, alu_out == 0);
        ec = m_pick(m_c, 0, alu_carry);
        after_ex  = m_pend - (ex_wr_valid ? 1 : 0);
        if (after_ex < 0) after_ex = 0;
        exp_stall = cond_valid && (after_ex != 0);
        check("model_flags", flags, {m_n, m_v, m_z, m_c});
        check("model_iss_ready", iss_ready, m_pend < MAX_PEND);
        check("model_stk_err", stk_err, m_err);
        check("model_cond_stall", cond_stall, exp_stall);
        if (!cond_stall) begin
            check("model_cond_true", cond_true,
                  cond_valid && m_cond(int'(cond_code), en, ev, ez, ec));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        iss_valid   = 0;
        ex_wr_valid = 0;
        ex_wr_mask  = 4'h0;
        alu_out     = '0;
        alu_ovfl    = 0;
        alu_carry   = 0;
        flush       = 0;
        cond_valid  = 0;
        cond_code   = 4'h0;
        save        = 0;
        restore     = 0;
    endtask

    task automatic ex(input logic [3:0] mask, input logic [DATA_W-1:0] res,
                      input logic ov, input logic cy);
        ex_wr_valid = 1;
        ex_wr_mask  = mask;
        alu_out     = res;
        alu_ovfl    = ov;
        alu_carry   = cy;
    endtask

    initial begin
        // 1. reset state, unconditional branch
        clear();
        rst = 1;
        cond_valid = 1;
        cond_code  = 4'd7;
        #3;
        check("rst_cond_true", cond_true, 1);
        check("rst_cond_stall", cond_stall, 0);
        check("rst_flags", flags, 4'b0000);
        check("rst_iss_ready", iss_ready, 1);
        check("rst_stk_err", stk_err, 0);
        tick();
        rst = 0;
        clear();

        // 2. full write of a negative result with carry
        tick();
        ex(4'hF, 16'h8000, 0, 1);
        tick();
        clear();
        cond_valid = 1;
        cond_code  = 4'd3;
        #1;
        check("wr_flags", flags, 4'b1001);
        check("wr_lt", cond_true, 1);
        cond_code = 4'd8;
        #1;
        check("wr_cs", cond_true, 1);
        cond_code = 4'd11;
        #1;
        check("wr_slt", cond_true, 1);

        // 3. stall on two in-flight writers, bypass on the last one
        tick();
        clear();
        iss_valid = 1;
        tick();
        iss_valid = 1;
        tick();
        clear();
        cond_valid = 1;
        cond_code  = 4'd1;
        #1;
        check("stall_two_pend", cond_stall, 1);
        tick();
        ex(4'hF, 16'h0005, 0, 0);
        #1;
        check("stall_one_left", cond_stall, 1);
        tick();
        ex(4'hF, 16'h0000, 0, 0);
        #1;
        check("bypass_stall", cond_stall, 0);
        check("bypass_eq", cond_true, 1);
        tick();
        clear();
        #1;
        check("bypass_flags", flags, 4'b0010);

        // 4. issue limit and flush
        iss_valid = 1;
        tick();
        tick();
        tick();
        #1;
        check("full_iss_ready", iss_ready, 0);
        tick();
        #1;
        check("full_no_count", iss_ready, 0);
        clear();
        flush = 1;
        tick();
        clear();
        cond_valid = 1;
        cond_code  = 4'd7;
        #1;
        check("flush_iss_ready", iss_ready, 1);
        check("flush_no_stall", cond_stall, 0);

        // 5. masked write touches only Z
        tick();
        clear();
        ex(4'hF, 16'h8000, 0, 1);
        tick();
        ex(4'b0010, 16'h0000, 1, 0);
        tick();
        clear();
        #1;
        check("mask_z_only", flags, 4'b1011);

        // 6. stack: four saves (pre-write values), overflow, restore priority, underflow
        save = 1;
        ex(4'hF, 16'h0000, 0, 0);
        tick();
        clear();
        save = 1;
        ex(4'hF, 16'h8000, 1, 1);
        tick();
        clear();
        save = 1;
        ex(4'hF, 16'h0001, 0, 0);
        tick();
        clear();
        save = 1;
        tick();
        clear();
        save = 1;
        tick();
        clear();
        #1;
        check("stk_overflow_err", stk_err, 1);
        check("stk_flags_after_saves", flags, 4'b0000);
        ex(4'hF, 16'h7FFF, 1, 1);
        tick();
        clear();
        #1;
        check("pre_restore_flags", flags, 4'b0101);
        restore = 1;
        ex(4'hF, 16'h8000, 0, 1);
        tick();
        clear();
        #1;
        check("restore_drops_ex", flags, 4'b0000);
        restore = 1;
        tick();
        clear();
        #1;
        check("restore_2", flags, 4'b1101);
        restore = 1;
        tick();
        clear();
        #1;
        check("restore_3", flags, 4'b0010);
        restore = 1;
        tick();
        clear();
        #1;
        check("restore_4", flags, 4'b1011);
        restore = 1;
        tick();
        clear();
        #1;
        check("underflow_hold", flags, 4'b1011);
        check("underflow_err", stk_err, 1);

        // 7. reset mid-operation discards stack, error and flags
        save = 1;
        tick();
        clear();
        #1;
        rst = 1;
        #1;
        check("midrst_err", stk_err, 0);
        check("midrst_flags", flags, 4'b0000);
        tick();
        rst = 0;
        restore = 1;
        tick();
        clear();
        #1;
        check("midrst_stack_empty", stk_err, 1);
        check("midrst_flags_hold", flags, 4'b0000);

        tick();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
